sccb_init_sequencer: RTL and testbench

- Upstream controller for SCCB_transceiver_core.
- After a start request, walks a register table of (sub_addr, data) pairs and issues one 3-phase write per entry.
- Handshakes on the transceiver's phase_done, inserts a settling delay where the table requests one, and reports completion or timeout to the top level.
- Sits between the system top (reset/start button) and the transceiver, so the OV7670 is configured before the VGA capture path is enabled.

---
 rtl/sccb_defs.sv | 32 +++
 rtl/ov7670_init_rom.sv | 52 +++++
 rtl/sccb_init_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_defs.sv
// Shared definitions for the SCCB init sequencer: phase codes,
// table markers and FSM state encoding.
package sccb_defs;

  localparam logic [2:0] PHASE_W3 = 3'b001;
  localparam logic [2:0] PHASE_W2 = 3'b010;
  localparam logic [2:0] PHASE_R2 = 3'b100;

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_DELAY  = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_ISSUE  = ST_ISSUE,
    S_WAIT   = ST_WAIT,
    S_GAP    = ST_GAP,
    S_DELAY  = ST_DELAY,
    S_DONE   = ST_DONE
  } state_t;

endpackage

// File: rtl/ov7670_init_rom.sv
// Register table for the OV7670, read with one cycle of latency.
// MODE selects an alternate table (1: short, 2: empty, 3: no END).
module ov7670_init_rom
  import sccb_defs::*;
#(
  parameter int AW   = 8,
  parameter int MODE = 0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] i_addr,
  output logic [15:0]   o_entry
);

  logic [15:0] w_entry;

  always_comb begin
    w_entry = ENTRY_END;
    if (MODE == 3) begin
      w_entry = {8'h20, 8'(i_addr)};
    end else if (MODE == 2) begin
      w_entry = ENTRY_END;
    end else if (MODE == 1) begin
      case (int'(i_addr))
        0:       w_entry = 16'h1280;
        1:       w_entry = ENTRY_DELAY;
        2:       w_entry = 16'h1214;
        default: w_entry = ENTRY_END;
      endcase
    end else begin
      // soft reset first, then settle before the real config
      case (int'(i_addr))
        0:       w_entry = 16'h1280;
        1:       w_entry = ENTRY_DELAY;
        2:       w_entry = 16'h1204;
        3:       w_entry = 16'h1100;
        4:       w_entry = 16'h0C00;
        5:       w_entry = 16'h3E00;
        6:       w_entry = 16'h40D0;
        7:       w_entry = 16'h3A04;
        8:       w_entry = 16'h8C00;
        default: w_entry = ENTRY_END;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_entry <= '0;
    else            o_entry <= w_entry;
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the init table and issues one 3-phase SCCB write per entry,
// with settling delays, bus-free gaps and a per-write timeout.
module sccb_init_sequencer
  import sccb_defs::*;
#(
  parameter int          CLK_FREQ_HZ    = 100_000_000,
  parameter int          DELAY_MS       = 10,
  parameter int          GAP_CYCLES     = 1000,
  parameter int          TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter int          ROM_AW         = 8,
  parameter int          ROM_MODE       = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [2:0]        i_phase_done,
  output logic [7:0]        o_main_addr,
  output logic [7:0]        o_sub_addr,
  output logic [7:0]        o_data,
  output logic [2:0]        o_phase,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_index
);

  localparam int DLY_RAW = DELAY_MS * (CLK_FREQ_HZ / 1000);
  localparam int DLY_LD  = (DLY_RAW > 0) ? DLY_RAW - 1 : 0;
  localparam int GAP_LD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LD   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int MAX_A   = (DLY_LD > GAP_LD) ? DLY_LD : GAP_LD;
  localparam int MAX_LD  = (MAX_A > TO_LD) ? MAX_A : TO_LD;
  localparam int CW      = (MAX_LD > 0) ? $clog2(MAX_LD + 1) : 1;

  state_t            r_state, w_state;
  logic [ROM_AW-1:0] r_index, w_index;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [2:0]        r_phase, w_phase;
  logic [7:0]        r_sub, w_sub;
  logic [7:0]        r_data, w_data;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_error, w_error;
  logic              r_pd_q;
  logic [15:0]       w_entry;
  logic              w_rise;
  logic              w_last;
  logic              w_unused_pd;

  ov7670_init_rom #(
    .AW   (ROM_AW),
    .MODE (ROM_MODE)
  ) u_rom (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_addr    (r_index),
    .o_entry   (w_entry)
  );

  assign w_rise      = i_phase_done[0] & ~r_pd_q;
  assign w_last      = (r_index == {ROM_AW{1'b1}});
  assign w_unused_pd = ^i_phase_done[2:1];

  always_comb begin
    w_state = r_state;
    w_index = r_index;
    w_cnt   = r_cnt;
    w_phase = r_phase;
    w_sub   = r_sub;
    w_data  = r_data;
    w_busy  = r_busy;
    w_done  = r_done;
    w_error = r_error;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_index = '0;
          w_error = 1'b0;
          w_done  = 1'b0;
          w_busy  = 1'b1;
          w_state = S_FETCH;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        if (w_entry == ENTRY_END) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else if (w_entry == ENTRY_DELAY) begin
          w_cnt   = CW'(DLY_LD);
          w_state = S_DELAY;
        end else begin
          w_sub   = w_entry[15:8];
          w_data  = w_entry[7:0];
          w_cnt   = CW'(TO_LD);
          w_phase = PHASE_W3;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: w_state = S_WAIT;
      S_WAIT: begin
        if (w_rise) begin
          w_phase = '0;
          if (w_last) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_index = r_index + ROM_AW'(1);
            w_cnt   = CW'(GAP_LD);
            w_state = S_GAP;
          end
        end else if (r_cnt == '0) begin
          w_phase = '0;
          w_error = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_state = S_FETCH;
        else             w_cnt   = r_cnt - CW'(1);
      end
      S_DELAY: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CW'(1);
        end else if (w_last) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_index = r_index + ROM_AW'(1);
          w_state = S_FETCH;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_sub   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_pd_q  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_index <= w_index;
      r_cnt   <= w_cnt;
      r_phase <= w_phase;
      r_sub   <= w_sub;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_error <= w_error;
      r_pd_q  <= i_phase_done[0];
    end
  end

  assign o_main_addr = DEV_ADDR;
  assign o_sub_addr  = r_sub;
  assign o_data      = r_data;
  assign o_phase     = r_phase;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_index     = r_index;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench: four sequencer instances (short, empty, timeout, no-END tables)
// against a table-walking reference and a random-latency responder.
module tb_sccb_init_sequencer;

  logic clk;
  logic rst_n;
  logic [3:0] start;
  logic [3:0] pd_b;
  logic [3:0] force_hi;
  logic [3:0] resp_en;
  logic [3:0][7:0] maddr, sub, dat, idx;
  logic [3:0][2:0] phase;
  logic [3:0] busy, done, err;
  int cyc;
  int checks;
  int errors;

  logic [23:0] wq[4][$];
  int rise_q[4][$];
  int fall_q[4][$];
  logic [23:0] exp_q[$];
  int exp_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sccb_init_sequencer #(.CLK_FREQ_HZ(20_000), .DELAY_MS(1), .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(100_000), .ROM_MODE(1)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[0]),
    .i_phase_done({2'b00, pd_b[0]}), .o_main_addr(maddr[0]),
    .o_sub_addr(sub[0]), .o_data(dat[0]), .o_phase(phase[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_index(idx[0]));

  sccb_init_sequencer #(.CLK_FREQ_HZ(20_000), .DELAY_MS(1), .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(100_000), .ROM_MODE(2)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[1]),
    .i_phase_done({2'b00, pd_b[1]}), .o_main_addr(maddr[1]),
    .o_sub_addr(sub[1]), .o_data(dat[1]), .o_phase(phase[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_index(idx[1]));

  sccb_init_sequencer #(.CLK_FREQ_HZ(20_000), .DELAY_MS(1), .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(100), .ROM_MODE(1)) u2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[2]),
    .i_phase_done({2'b00, pd_b[2]}), .o_main_addr(maddr[2]),
    .o_sub_addr(sub[2]), .o_data(dat[2]), .o_phase(phase[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_error(err[2]), .o_index(idx[2]));

  sccb_init_sequencer #(.CLK_FREQ_HZ(20_000), .DELAY_MS(1), .GAP_CYCLES(4),
    .TIMEOUT_CYCLES(100_000), .ROM_MODE(3)) u3 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start[3]),
    .i_phase_done({2'b00, pd_b[3]}), .o_main_addr(maddr[3]),
    .o_sub_addr(sub[3]), .o_data(dat[3]), .o_phase(phase[3]),
    .o_busy(busy[3]), .o_done(done[3]), .o_error(err[3]), .o_index(idx[3]));

  for (genvar g = 0; g < 4; g++) begin : g_side
    int cnt;
    int lat;
    logic lvl;
    logic prev = 1'b0;
    // transceiver stand-in: replies a random 40..80 cycles after o_phase[0]
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= 0;
        lvl <= 1'b0;
        lat <= 50;
      end else if (!phase[g][0]) begin
        cnt <= 0;
        lvl <= 1'b0;
        lat <= int'($urandom_range(40, 80));
      end else begin
        cnt <= cnt + 1;
        if (resp_en[g] && cnt >= lat) lvl <= 1'b1;
      end
    end
    assign pd_b[g] = lvl | force_hi[g];
    always @(negedge clk) begin
      prev <= phase[g][0];
      if (phase[g][0] && !prev) begin
        wq[g].push_back({maddr[g], sub[g], dat[g]});
        rise_q[g].push_back(cyc);
      end
      if (!phase[g][0] && prev) fall_q[g].push_back(cyc);
    end
  end

  function automatic logic [15:0] tbl(input int mode, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (mode == 2) return 16'hFFFF;
    if (mode == 3) return {8'h20, b};
    case (i)
      0: return 16'h1280;
      1: return 16'hFFF0;
      2: return 16'h1214;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic ref_run(input int mode);
    logic [15:0] e;
    exp_q.delete();
    exp_idx = 255;
    for (int i = 0; i < 256; i++) begin
      e = tbl(mode, i);
      if (e == 16'hFFFF) begin
        exp_idx = i;
        break;
      end
      if (e != 16'hFFF0) exp_q.push_back({8'h42, e});
    end
  endtask

  task automatic clear_mon(input int g);
    wq[g].delete();
    rise_q[g].delete();
    fall_q[g].delete();
  endtask

  task automatic pulse(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output bit ok);
    int n;
    n = 0;
    while (!done[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = done[g];
  endtask

  task automatic wait_rises(input int g, input int k, input int budget,
                            output bit ok);
    int n;
    n = 0;
    while (rise_q[g].size() < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rise_q[g].size() >= k);
  endtask

  task automatic test_reset;
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({phase[g], busy[g], done[g], err[g], idx[g], sub[g], dat[g]} !== 33'd0
          || maddr[g] !== 8'h42) begin
        errors++;
        $display("FAIL reset[%0d]: ph=%0h b=%0b d=%0b e=%0b i=%0h s=%0h dt=%0h ma=%0h, required all 0, ma=42",
                 g, phase[g], busy[g], done[g], err[g], idx[g], sub[g], dat[g], maddr[g]);
      end
    end
  endtask

  task automatic test_sequence;
    bit ok;
    clear_mon(0);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    pulse(0);
    wait_done(0, 5000, ok);
    ref_run(1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL seq_done: done=%0b, required 1 within 5000 cycles", done[0]);
    end
    checks++;
    if ({busy[0], err[0]} !== 2'b00 || idx[0] !== 8'(exp_idx)) begin
      errors++;
      $display("FAIL seq_final: busy=%0b err=%0b idx=%0d, required 0 0 %0d",
               busy[0], err[0], idx[0], exp_idx);
    end
    checks++;
    if (wq[0].size() !== exp_q.size()) begin
      errors++;
      $display("FAIL seq_count: %0d writes, required %0d", wq[0].size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq[0].size(); i++) begin
      checks++;
      if (wq[0][i] !== exp_q[i]) begin
        errors++;
        $display("FAIL seq_write[%0d]: %06h, required %06h", i, wq[0][i], exp_q[i]);
      end
    end
    // bus-free gap plus the 20-cycle settle sit between the two writes
    checks++;
    if (fall_q[0].size() < 1 || rise_q[0].size() < 2
        || rise_q[0][1] - fall_q[0][0] < 24) begin
      errors++;
      $display("FAIL seq_settle: fall/rise counts %0d/%0d, gap too short or missing, required >= 24",
               fall_q[0].size(), rise_q[0].size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_mon(0);
    pulse(0);
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%0b busy=%0b, required 0 1", done[0], busy[0]);
    end
    wait_rises(0, 1, 500, ok);
    repeat ($urandom_range(1, 30)) @(negedge clk);
    pulse(0);
    wait_done(0, 5000, ok);
    ref_run(1);
    checks++;
    if (!ok || wq[0].size() !== exp_q.size() || idx[0] !== 8'(exp_idx)) begin
      errors++;
      $display("FAIL b2b_ignore: done=%0b writes=%0d idx=%0d, required 1 %0d %0d",
               done[0], wq[0].size(), idx[0], exp_q.size(), exp_idx);
    end
  endtask

  task automatic test_end_first;
    clear_mon(1);
    pulse(1);
    checks++;
    if (done[1] !== 1'b0 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL end_accept: done=%0b busy=%0b, required 0 1", done[1], busy[1]);
    end
    @(negedge clk);
    checks++;
    if (done[1] !== 1'b0) begin
      errors++;
      $display("FAIL end_early: done=%0b one cycle after start, required 0", done[1]);
    end
    @(negedge clk);
    checks++;
    if (done[1] !== 1'b1 || busy[1] !== 1'b0 || idx[1] !== 8'd0) begin
      errors++;
      $display("FAIL end_done: done=%0b busy=%0b idx=%0d, required 1 0 0",
               done[1], busy[1], idx[1]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (wq[1].size() !== 0) begin
      errors++;
      $display("FAIL end_phase: %0d writes issued, required 0", wq[1].size());
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int t0;
    resp_en[2] = 1'b0;
    clear_mon(2);
    pulse(2);
    wait_rises(2, 1, 100, ok);
    t0 = ok ? rise_q[2][0] : cyc;
    wait_done(2, 500, ok);
    checks++;
    if (!ok || err[2] !== 1'b1 || (cyc - t0) < 95 || (cyc - t0) > 105) begin
      errors++;
      $display("FAIL timeout_when: done=%0b err=%0b after %0d cycles, required 1 1 ~100",
               done[2], err[2], cyc - t0);
    end
    checks++;
    if (phase[2] !== 3'd0 || busy[2] !== 1'b0 || idx[2] !== 8'd0) begin
      errors++;
      $display("FAIL timeout_state: phase=%0h busy=%0b idx=%0d, required 0 0 0",
               phase[2], busy[2], idx[2]);
    end
    resp_en[2] = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    clear_mon(0);
    pulse(0);
    wait_rises(0, 2, 1000, ok);
    repeat ($urandom_range(5, 30)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || phase[0] !== 3'd0 || busy[0] !== 1'b0 || idx[0] !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: reached=%0b phase=%0h busy=%0b idx=%0d, required 1 0 0 0",
               ok, phase[0], busy[0], idx[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon(0);
    pulse(0);
    wait_done(0, 5000, ok);
    ref_run(1);
    checks++;
    if (!ok || wq[0].size() !== exp_q.size() || wq[0].size() < 1
        || wq[0][0] !== exp_q[0]) begin
      errors++;
      $display("FAIL rst_rerun: done=%0b writes=%0d, required 1 %0d from entry 0",
               done[0], wq[0].size(), exp_q.size());
    end
  endtask

  task automatic test_stale;
    bit ok;
    resp_en[0] = 1'b0;
    force_hi[0] = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon(0);
    pulse(0);
    repeat (150) @(negedge clk);
    checks++;
    if (idx[0] !== 8'd0 || busy[0] !== 1'b1 || phase[0] !== 3'b001) begin
      errors++;
      $display("FAIL stale_hold: idx=%0d busy=%0b phase=%0h, required 0 1 1",
               idx[0], busy[0], phase[0]);
    end
    force_hi[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (idx[0] !== 8'd0) begin
      errors++;
      $display("FAIL stale_fall: idx=%0d, required 0", idx[0]);
    end
    force_hi[0] = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (idx[0] !== 8'd1 || phase[0] !== 3'd0) begin
      errors++;
      $display("FAIL stale_rise: idx=%0d phase=%0h, required 1 0", idx[0], phase[0]);
    end
    force_hi[0] = 1'b0;
    resp_en[0] = 1'b1;
    wait_done(0, 5000, ok);
    checks++;
    if (!ok || err[0] !== 1'b0 || wq[0].size() !== 2) begin
      errors++;
      $display("FAIL stale_finish: done=%0b err=%0b writes=%0d, required 1 0 2",
               done[0], err[0], wq[0].size());
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int n;
    clear_mon(3);
    pulse(3);
    wait_done(3, 40000, ok);
    ref_run(3);
    checks++;
    if (!ok || err[3] !== 1'b0 || idx[3] !== 8'(exp_idx)) begin
      errors++;
      $display("FAIL wrap_final: done=%0b err=%0b idx=%0d, required 1 0 %0d",
               done[3], err[3], idx[3], exp_idx);
    end
    checks++;
    if (wq[3].size() !== exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: %0d writes, required %0d", wq[3].size(), exp_q.size());
    end
    n = 0;
    for (int i = 0; i < exp_q.size() && i < wq[3].size(); i++)
      if (wq[3][i] !== exp_q[i]) n++;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL wrap_writes: %0d entries differ, required 0", n);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start = '0;
    force_hi = '0;
    resp_en = '1;
    cyc = 0;
    checks = 0;
    errors = 0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_sequence;
    test_back_to_back;
    test_end_first;
    test_timeout;
    test_reset_mid;
    test_stale;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
